// File: rtl/chess_pkg.sv
// chess_pkg: shared state encodings and player-index helpers for the chess clock
package chess_pkg;

    localparam int MAX_PLAYERS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_FLAG  = 2'b11
    } state_t;

    function automatic int next_player(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

    function automatic logic [MAX_PLAYERS-1:0] onehot(input int idx);
        return MAX_PLAYERS'(1) << idx;
    endfunction

endpackage

// File: rtl/edge_detect_n.sv
// edge_detect_n: registers a button vector and flags rising edges so a held button acts once
module edge_detect_n #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] press_q;

    // previous-cycle copy of the buttons
    always_ff @(posedge clk) begin
        if (reset) press_q <= '0;
        else       press_q <= level;
    end

    assign rise = level & ~press_q;

endmodule

// File: rtl/turn_control_n.sv
// turn_control_n: turn arbitration and timer strobes for an N-player chess clock
module turn_control_n
    import chess_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int IDX_W       = 3,
    parameter int INC_MODE    = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   pause,
    input  logic [NUM_PLAYERS-1:0] press,
    input  logic [NUM_PLAYERS-1:0] time_out,
    output logic [NUM_PLAYERS-1:0] timer_en,
    output logic [NUM_PLAYERS-1:0] timer_load,
    output logic [NUM_PLAYERS-1:0] incr_pulse,
    output logic [IDX_W-1:0]       active,
    output logic [NUM_PLAYERS-1:0] flag,
    output logic [1:0]             state
);

    state_t                 st;
    logic [NUM_PLAYERS-1:0] rise;
    logic [NUM_PLAYERS-1:0] act_oh;
    logic [NUM_PLAYERS-1:0] nxt_oh;
    logic [NUM_PLAYERS-1:0] start_oh;
    logic [IDX_W-1:0]       nxt;
    logic [IDX_W-1:0]       start;
    logic                   hit;
    logic                   handover;
    int                     first;

    edge_detect_n #(.WIDTH(NUM_PLAYERS)) u_edge (
        .clk   (clk),
        .reset (reset),
        .level (press),
        .rise  (rise)
    );

    // lowest pressed index picks the starter; derive successor indices and their one-hot forms
    always_comb begin
        first = 0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--)
            if (rise[i]) first = i;
        nxt      = IDX_W'(next_player(int'(active), NUM_PLAYERS));
        start    = IDX_W'(next_player(first, NUM_PLAYERS));
        act_oh   = NUM_PLAYERS'(onehot(int'(active)));
        nxt_oh   = NUM_PLAYERS'(onehot(int'(nxt)));
        start_oh = NUM_PLAYERS'(onehot(int'(start)));
        hit      = |(time_out & act_oh);
        handover = |(rise & act_oh);
    end

    // turn FSM: enable low beats timeout beats pause beats handover
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= ST_IDLE;
            active     <= '0;
            timer_en   <= '0;
            timer_load <= '0;
            incr_pulse <= '0;
            flag       <= '0;
        end else begin
            timer_load <= '0;
            incr_pulse <= '0;
            if (!enable) begin
                st         <= ST_IDLE;
                timer_en   <= '0;
                flag       <= '0;
                timer_load <= (st != ST_IDLE) ? '1 : '0;
            end else begin
                case (st)
                    ST_IDLE: if (|rise) begin
                        st       <= ST_RUN;
                        active   <= start;
                        timer_en <= start_oh;
                    end
                    ST_RUN: if (hit) begin
                        st       <= ST_FLAG;
                        flag     <= act_oh;
                        timer_en <= '0;
                    end else if (pause) begin
                        st       <= ST_PAUSE;
                        timer_en <= '0;
                    end else if (handover) begin
                        active     <= nxt;
                        timer_en   <= nxt_oh;
                        incr_pulse <= (INC_MODE != 0) ? act_oh : '0;
                    end
                    ST_PAUSE: if (!pause) begin
                        st       <= ST_RUN;
                        timer_en <= act_oh;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_turn_control_n.sv
// tb_turn_control_n: directed vectors on a 2-player Fischer instance and a 3-player plain instance
module tb_turn_control_n;

    logic       clk = 0;
    logic       reset;
    int         vectors = 0;
    int         miscompares = 0;

    logic       a_enable, a_pause;
    logic [1:0] a_press, a_time_out, a_timer_en, a_timer_load, a_incr_pulse, a_flag, a_state;
    logic [2:0] a_active;

    logic       b_enable, b_pause;
    logic [2:0] b_press, b_time_out, b_timer_en, b_timer_load, b_incr_pulse, b_flag;
    logic [1:0] b_state;
    logic [2:0] b_active;

    always #5 clk = ~clk;

    turn_control_n #(.NUM_PLAYERS(2), .IDX_W(3), .INC_MODE(1)) dut_a (
        .clk(clk), .reset(reset), .enable(a_enable), .pause(a_pause), .press(a_press),
        .time_out(a_time_out), .timer_en(a_timer_en), .timer_load(a_timer_load),
        .incr_pulse(a_incr_pulse), .active(a_active), .flag(a_flag), .state(a_state)
    );

    turn_control_n #(.NUM_PLAYERS(3), .IDX_W(3), .INC_MODE(0)) dut_b (
        .clk(clk), .reset(reset), .enable(b_enable), .pause(b_pause), .press(b_press),
        .time_out(b_time_out), .timer_en(b_timer_en), .timer_load(b_timer_load),
        .incr_pulse(b_incr_pulse), .active(b_active), .flag(b_flag), .state(b_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1;
        a_enable = 1; a_pause = 0; a_press = 2'b11; a_time_out = 0;
        b_enable = 0; b_pause = 0; b_press = 0;     b_time_out = 0;
        step(); step();
        check("rst_state", a_state, 0);
        check("rst_en", a_timer_en, 0);
        check("rst_active", a_active, 0);
        check("rst_load", a_timer_load, 0);
        check("rst_flag", a_flag, 0);
        check("rst_incr", a_incr_pulse, 0);

        reset = 0;
        step();
        check("start_state", a_state, 1);
        check("start_active", a_active, 1);
        check("start_en", a_timer_en, 2'b10);

        a_press = 2'b00; step();
        check("hold_active", a_active, 1);

        a_press = 2'b10; step();
        check("ho1_active", a_active, 0);
        check("ho1_en", a_timer_en, 2'b01);
        check("ho1_incr", a_incr_pulse, 2'b10);
        step();
        check("ho1_incr_once", a_incr_pulse, 0);
        a_press = 2'b01; step();
        check("inc_pulse", a_incr_pulse, 2'b01);
        check("inc_active", a_active, 1);
        step();
        check("inc_held_nopulse", a_incr_pulse, 0);
        check("inc_held_active", a_active, 1);

        a_press = 2'b00; step();
        a_pause = 1; a_press = 2'b10; step();
        check("pause_state", a_state, 2);
        check("pause_en", a_timer_en, 0);
        check("pause_active", a_active, 1);
        a_press = 2'b00; step();
        check("pause_hold", a_state, 2);
        a_pause = 0; step();
        check("resume_state", a_state, 1);
        check("resume_active", a_active, 1);
        check("resume_en", a_timer_en, 2'b10);

        a_press = 2'b01; a_time_out = 2'b01; step();
        check("nonact_active", a_active, 1);
        check("nonact_en", a_timer_en, 2'b10);
        check("nonact_flag", a_flag, 0);
        check("nonact_state", a_state, 1);
        a_press = 2'b00; a_time_out = 2'b00; step();

        a_press = 2'b10; a_time_out = 2'b10; step();
        check("flag_state", a_state, 3);
        check("flag_bits", a_flag, 2'b10);
        check("flag_en", a_timer_en, 0);
        check("flag_noinc", a_incr_pulse, 0);
        a_press = 2'b00; a_time_out = 2'b00; step();
        check("flag_hold", a_flag, 2'b10);
        a_enable = 0; step();
        check("idle_state", a_state, 0);
        check("idle_flag", a_flag, 0);
        check("idle_load", a_timer_load, 2'b11);
        step();
        check("idle_load_once", a_timer_load, 0);

        a_enable = 1; a_press = 2'b01; step();
        check("restart_active", a_active, 1);
        reset = 1; step();
        check("midrst_state", a_state, 0);
        check("midrst_en", a_timer_en, 0);
        check("midrst_active", a_active, 0);
        check("midrst_load", a_timer_load, 0);
        check("b_idle_noload", b_timer_load, 0);
        reset = 0; a_press = 2'b00; step();

        b_enable = 1; b_press = 3'b001; step();
        check("b_start_active", b_active, 1);
        check("b_start_en", b_timer_en, 3'b010);
        b_press = 0; step();
        b_press = 3'b010; step();
        check("b_ho1_active", b_active, 2);
        check("b_ho1_en", b_timer_en, 3'b100);
        check("b_noinc", b_incr_pulse, 0);
        b_press = 0; step();
        b_press = 3'b100; step();
        check("b_wrap_active", b_active, 0);
        check("b_wrap_en", b_timer_en, 3'b001);
        b_press = 0; step();
        b_press = 3'b001; step();
        check("b_ho3_active", b_active, 1);
        check("b_ho3_en", b_timer_en, 3'b010);
        b_press = 0; b_time_out = 3'b010; step();
        check("b_flag_bits", b_flag, 3'b010);
        check("b_flag_state", b_state, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
